// File: rtl/store_align_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_align_pkg
// Purpose  : Shared size encodings, FSM states and legality/split helpers.
//            Behaviour of the helpers depends on STORE_ALIGN_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
package store_align_pkg;

  localparam int unsigned c_lanes = 4;

  localparam logic [1:0] c_size_byte = 2'b00;
  localparam logic [1:0] c_size_half = 2'b01;
  localparam logic [1:0] c_size_word = 2'b10;
  localparam logic [1:0] c_size_rsvd = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_t;

  // True when the access spans two memory words.
  function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
`ifdef STORE_ALIGN_SPLIT_EN
    return ((size == c_size_half) && (off == 2'd3)) ||
           ((size == c_size_word) && (off != 2'd0));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_legal(input logic [1:0] size, input logic [1:0] off);
`ifdef STORE_ALIGN_SPLIT_EN
    return size != c_size_rsvd;
`else
    return (size == c_size_byte) ||
           ((size == c_size_half) && !off[0]) ||
           ((size == c_size_word) && (off == 2'd0));
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_align_if.sv
`default_nettype none
// ============================================================================
// Module   : store_align_if
// Purpose  : Store request channel plus memory write-beat channel.
// Revision : 1.0 - initial release
// ============================================================================
interface store_align_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, err
  );

endinterface
`default_nettype wire

// File: rtl/lane_pack.sv
`default_nettype none
// ============================================================================
// Module   : lane_pack
// Purpose  : Combinational byte-enable / write-data lane placement for one
//            beat. Split beats exist only with STORE_ALIGN_SPLIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lane_pack
  import store_align_pkg::*;
(
  input  wire logic [1:0]  i_size,
  input  wire logic [1:0]  i_off,
  input  wire logic [31:0] i_data,
  input  wire logic        i_beat,
  output logic      [3:0]  o_be,
  output logic      [31:0] o_wdata
);

  logic [1:0] w_neg_off;
  logic [4:0] w_sh_lo;
  logic [4:0] w_sh_hi;

  // 4-off taken modulo 4; only used when off != 0
  assign w_neg_off = 2'd0 - i_off;
  assign w_sh_lo   = {i_off, 3'b000};
  assign w_sh_hi   = {w_neg_off, 3'b000};

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    if (needs_split(i_size, i_off)) begin
      if (!i_beat) begin
        o_be    = 4'b1111 << i_off;
        o_wdata = i_data << w_sh_lo;
      end else begin
        o_be    = ~(4'b1111 << i_off) & ((i_size == c_size_half) ? 4'b0001 : 4'b1111);
        o_wdata = i_data >> w_sh_hi;
      end
    end else begin
      case (i_size)
        c_size_byte: begin
          o_be    = 4'b0001 << i_off;
          o_wdata = {4{i_data[7:0]}};
        end
        c_size_half: begin
          o_be    = 4'b0011 << i_off;
          o_wdata = {2{i_data[15:0]}};
        end
        c_size_word: begin
          o_be    = 4'b1111;
          o_wdata = i_data;
        end
        default: begin
          o_be    = 4'b0000;
          o_wdata = 32'h0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module   : store_align
// Purpose  : Converts a byte-addressed store into one or two word-aligned
//            memory write beats. Macro STORE_ALIGN_SPLIT_EN enables splitting.
// Revision : 1.0 - initial release
// ============================================================================
module store_align
  import store_align_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  store_align_if.slave     bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [1:0]  r_size;
  logic        r_done;
  logic        r_err;

  logic        w_accept;
  logic        w_legal;
  logic        w_split;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_beat1;
  logic        w_mem_valid;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_addr;

  assign bus.req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_legal       = is_legal(bus.req_size, bus.req_addr[1:0]);
  assign w_split       = needs_split(r_size, r_addr[1:0]);
  assign w_beat1       = (r_state == ST_BEAT1);
  assign w_mem_valid   = (r_state == ST_BEAT0) || (r_state == ST_BEAT1);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_legal) w_state_nxt = ST_BEAT0;
          else         w_err_nxt   = 1'b1;
        end
      end
      ST_BEAT0: begin
        if (bus.mem_ready) begin
          if (w_split) begin
            w_state_nxt = ST_BEAT1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      ST_BEAT1: begin
        if (bus.mem_ready) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
      r_size  <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_addr <= bus.req_addr;
        r_data <= bus.req_data;
        r_size <= bus.req_size;
      end
    end
  end

  lane_pack u_lane_pack (
    .i_size  (r_size),
    .i_off   (r_addr[1:0]),
    .i_data  (r_data),
    .i_beat  (w_beat1),
    .o_be    (w_be),
    .o_wdata (w_wdata)
  );

  // Second beat targets the next word; the add wraps naturally at 2^32.
  assign w_addr = {r_addr[31:2], 2'b00} + (w_beat1 ? 32'(c_lanes) : 32'd0);

  assign bus.mem_valid = w_mem_valid;
  assign bus.mem_addr  = w_mem_valid ? w_addr  : 32'h0;
  assign bus.mem_wdata = w_mem_valid ? w_wdata : 32'h0;
  assign bus.mem_be    = w_mem_valid ? w_be    : 4'b0000;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

endmodule
`default_nettype wire
